// File: rtl/wpa2_mem_pkg.sv
// Shared types and constants for the WPA2 memory block master.
package wpa2_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/wpa2_mem_rd_fifo.sv
// Show-ahead read-return FIFO: head word is always visible on o_data while not empty.
module wpa2_mem_rd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_clr_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push & !w_full;
    assign w_pop   = i_pop & !w_empty;

    // Storage has no reset so it can map onto plain RAM/regfile cells.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/wpa2_mem_block_master.sv
// Avalon-MM master moving word blocks between on-chip memory and the hash
// datapath: reads stream out on src, writes are fed from snk.
module wpa2_mem_block_master
    import wpa2_mem_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int LEN_W      = 13,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_read,
    output logic              o_avm_write,
    output logic [3:0]        o_avm_byteenable,
    output logic [31:0]       o_avm_writedata,
    input  logic              i_avm_waitrequest,
    input  logic [31:0]       i_avm_readdata,
    input  logic              i_avm_readdatavalid,
    output logic [31:0]       o_src_data,
    output logic              o_src_valid,
    input  logic              i_src_ready,
    input  logic [31:0]       i_snk_data,
    input  logic              i_snk_valid,
    output logic              o_snk_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_pending;
    logic               r_avm_write;
    logic [31:0]        r_wdata;

    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_empty;
    logic [31:0]        w_fifo_data;
    logic [CNT_W:0]     w_credit;
    logic [ADDR_W-1:0]  w_addr_next;
    logic               w_rd_req;
    logic               w_rd_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_exit;
    logic               w_wr_done;
    logic               w_snk_ready;
    logic               w_snk_beat;
    logic               w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^i_cmd_addr[1:0];

    // Outstanding reads plus buffered words never exceed the FIFO size,
    // so every returning word is guaranteed a slot.
    assign w_credit    = {1'b0, r_pending} + {1'b0, w_fifo_count};
    assign w_rd_req    = (r_state == ST_RD) && (r_remaining != '0) &&
                         (w_credit < (CNT_W+1)'(FIFO_DEPTH));
    assign w_rd_issue  = w_rd_req & !i_avm_waitrequest;
    assign w_push      = (r_state == ST_RD) & i_avm_readdatavalid;
    assign w_pop       = !w_fifo_empty & i_src_ready;
    assign w_addr_next = r_addr + ADDR_W'(BYTES_PER_WORD);

    // Leave RD on the cycle the last word is popped, not one cycle later.
    assign w_rd_exit   = (r_remaining == '0) && (r_pending == '0) && !w_push &&
                         ((w_fifo_count == '0) || ((w_fifo_count == CNT_W'(1)) && w_pop));

    assign w_wr_done   = r_avm_write & !i_avm_waitrequest;
    assign w_snk_ready = (r_state == ST_WR) && (r_remaining != '0) &&
                         (!r_avm_write || !i_avm_waitrequest);
    assign w_snk_beat  = w_snk_ready & i_snk_valid;

    wpa2_mem_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_rd_fifo (
        .i_clk   (i_clk),
        .i_clr_n (i_reset_n),
        .i_push  (w_push),
        .i_data  (i_avm_readdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_pending   <= '0;
            r_avm_write <= 1'b0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr      <= {i_cmd_addr[ADDR_W-1:2], 2'b00};
                        r_remaining <= i_cmd_len;
                        r_state     <= (i_cmd_len == '0) ? ST_FIN :
                                       (i_cmd_write ? ST_WR : ST_RD);
                    end
                end
                ST_RD: begin
                    if (w_rd_issue) begin
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - 1'b1;
                    end
                    case ({w_rd_issue, w_push})
                        2'b10:   r_pending <= r_pending + 1'b1;
                        2'b01:   if (r_pending != '0) r_pending <= r_pending - 1'b1;
                        default: r_pending <= r_pending;
                    endcase
                    if (w_rd_exit) r_state <= ST_FIN;
                end
                ST_WR: begin
                    if (w_wr_done) begin
                        r_addr      <= w_addr_next;
                        r_avm_write <= 1'b0;
                    end
                    // A new beat in the completion cycle keeps the write asserted.
                    if (w_snk_beat) begin
                        r_wdata     <= i_snk_data;
                        r_avm_write <= 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                    if (w_wr_done && (r_remaining == '0)) r_state <= ST_FIN;
                end
                ST_FIN:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready      = (r_state == ST_IDLE);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = (r_state == ST_FIN);
    assign o_avm_address    = r_addr;
    assign o_avm_read       = w_rd_req;
    assign o_avm_write      = r_avm_write;
    assign o_avm_byteenable = BYTEENABLE_ALL;
    assign o_avm_writedata  = r_wdata;
    assign o_src_data       = w_fifo_data;
    assign o_src_valid      = !w_fifo_empty;
    assign o_snk_ready      = w_snk_ready;

endmodule

// File: tb/tb_wpa2_mem_block_master.sv
// Bench for wpa2_mem_block_master: Avalon slave memory with latency/stall
// control, stream drivers, and a word-array reference model.
module tb_wpa2_mem_block_master;

    localparam int NWORDS = 8192;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [14:0] cmd_addr = '0;
    logic [12:0] cmd_len = '0;
    logic        cmd_ready, busy, done;
    logic [14:0] avm_address;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata, avm_readdata;
    logic [31:0] src_data;
    logic        src_valid, snk_ready;
    logic        src_ready = 1'b0;
    logic [31:0] snk_data = '0;
    logic        snk_valid = 1'b0;

    always #5 clk = ~clk;

    wpa2_mem_block_master dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .o_busy(busy), .o_done(done),
        .o_avm_address(avm_address), .o_avm_read(avm_read), .o_avm_write(avm_write),
        .o_avm_byteenable(avm_byteenable), .o_avm_writedata(avm_writedata),
        .i_avm_waitrequest(avm_waitrequest), .i_avm_readdata(avm_readdata),
        .i_avm_readdatavalid(avm_readdatavalid),
        .o_src_data(src_data), .o_src_valid(src_valid), .i_src_ready(src_ready),
        .i_snk_data(snk_data), .i_snk_valid(snk_valid), .o_snk_ready(snk_ready)
    );

    // ---------------- slave memory model ----------------
    int          lat = 1;
    logic        stall_mode = 1'b0, rnd_mode = 1'b0;
    int          sc = 0;
    logic        r_rndw = 1'b0;
    logic [32:0] pipe [0:7] = '{default: '0};
    logic [31:0] mem [0:NWORDS-1];
    logic        wflag [0:NWORDS-1] = '{default: 1'b0};

    function automatic logic [31:0] slave_word(input logic [12:0] idx);
        return wflag[idx] ? mem[idx] : (32'hA500_0000 + 32'(idx));
    endfunction

    assign avm_waitrequest   = stall_mode ? (avm_write && sc < 2) : r_rndw;
    assign avm_readdatavalid = pipe[0][32];
    assign avm_readdata      = pipe[0][31:0];

    always @(posedge clk) begin
        for (int k = 0; k < 7; k++) pipe[k] <= pipe[k+1];
        pipe[7] <= '0;
        if (avm_read && !avm_waitrequest) pipe[lat-1] <= {1'b1, slave_word(avm_address[14:2])};
        if (avm_write && !avm_waitrequest) begin
            mem[avm_address[14:2]]   <= avm_writedata;
            wflag[avm_address[14:2]] <= 1'b1;
        end
        if (avm_write) sc <= avm_waitrequest ? sc + 1 : 0;
        r_rndw <= rnd_mode && ($urandom_range(0, 3) == 0);
    end

    // ---------------- reference model and bookkeeping ----------------
    logic [31:0] ref_mem [0:NWORDS-1];
    int errors = 0, checks = 0;

    function automatic logic [14:0] word_addr(input logic [14:0] base, input int i);
        return {base[14:2], 2'b00} + 15'(4 * i);
    endfunction

    int          cyc, acc_cyc, done_cyc, done_cnt, rd_seen, wr_seen, hold_viol;
    bit          timeout;
    int          src_mode = 0, snk_mode = 0;
    logic [1023:0] rd_trace;
    logic [31:0] q_src[$];   int q_src_cyc[$];
    logic [14:0] q_iss[$];   int q_iss_cyc[$];
    logic [14:0] q_wa[$];    logic [31:0] q_wd[$];  int q_wc[$];
    logic [31:0] q_snk[$];

    // Presents one command and records every bus/stream event per cycle.
    task automatic run_op(input logic wr, input logic [14:0] addr, input logic [12:0] len,
                          input int max_cyc);
        logic        pw_rd, pw_wr;
        logic [14:0] pa;
        logic [31:0] pd;
        q_src.delete(); q_src_cyc.delete(); q_iss.delete(); q_iss_cyc.delete();
        q_wa.delete(); q_wd.delete(); q_wc.delete();
        acc_cyc = -1; done_cyc = -1; done_cnt = 0; rd_seen = 0; wr_seen = 0;
        hold_viol = 0; timeout = 0; rd_trace = '0;
        pw_rd = 0; pw_wr = 0; pa = '0; pd = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cmd_valid = (acc_cyc < 0); cmd_write = wr; cmd_addr = addr; cmd_len = len;
            case (src_mode)
                0: src_ready = 1'b1;
                1: src_ready = (cyc >= 30);
                default: src_ready = ($urandom_range(0, 1) == 1);
            endcase
            snk_valid = (q_snk.size() > 0) && (snk_mode == 0 || $urandom_range(0, 2) != 0);
            snk_data  = (q_snk.size() > 0) ? q_snk[0] : 32'h0;
            #1;
            if (pw_rd && !(avm_read && avm_address == pa)) hold_viol++;
            if (pw_wr && !(avm_write && avm_address == pa && avm_writedata == pd)) hold_viol++;
            pw_rd = avm_read && avm_waitrequest;
            pw_wr = avm_write && avm_waitrequest;
            pa = avm_address; pd = avm_writedata;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (cyc < 1024) rd_trace[cyc] = avm_read;
            if (avm_read) rd_seen++;
            if (avm_write) wr_seen++;
            if (avm_read && !avm_waitrequest) begin q_iss.push_back(avm_address); q_iss_cyc.push_back(cyc); end
            if (avm_write && !avm_waitrequest) begin
                q_wa.push_back(avm_address); q_wd.push_back(avm_writedata); q_wc.push_back(cyc);
            end
            if (src_valid && src_ready) begin q_src.push_back(src_data); q_src_cyc.push_back(cyc); end
            if (snk_valid && snk_ready) void'(q_snk.pop_front());
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (cyc >= max_cyc) begin timeout = 1; break; end
            cyc++;
        end
        cmd_valid = 1'b0; src_ready = 1'b0; snk_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, avm_read, avm_write, src_valid, snk_ready} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {cmd_ready, busy, done, avm_read, avm_write, src_valid, snk_ready});
        end
        checks++;
        if (avm_address !== 15'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", avm_address); end
        checks++;
        if (avm_writedata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", avm_writedata); end
        checks++;
        if (avm_byteenable !== 4'hF) begin errors++; $display("FAIL byteenable: got %h want f", avm_byteenable); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL post_reset_idle: got %b want 10", {cmd_ready, busy}); end
    endtask

    task automatic test_read_basic;
        lat = 1; stall_mode = 0; rnd_mode = 0; src_mode = 0;
        run_op(1'b0, 15'h0010, 13'd4, 60);
        checks++;
        if (timeout) begin errors++; $display("FAIL rd_basic_timeout: got no done want done"); end
        checks++;
        if (q_iss.size() !== 4) begin errors++; $display("FAIL rd_basic_issue_cnt: got %0d want 4", q_iss.size()); end
        for (int i = 0; i < 4 && i < q_iss.size(); i++) begin
            checks++;
            if (q_iss[i] !== 15'h0010 + 15'(4 * i)) begin
                errors++; $display("FAIL rd_basic_addr%0d: got %h want %h", i, q_iss[i], 15'h0010 + 15'(4 * i));
            end
            if (i > 0) begin
                checks++;
                if (q_iss_cyc[i] !== q_iss_cyc[i-1] + 1) begin
                    errors++; $display("FAIL rd_basic_b2b%0d: got cycle %0d want %0d", i, q_iss_cyc[i], q_iss_cyc[i-1] + 1);
                end
            end
        end
        checks++;
        if (q_src.size() !== 4) begin errors++; $display("FAIL rd_basic_beats: got %0d want 4", q_src.size()); end
        for (int i = 0; i < 4 && i < q_src.size(); i++) begin
            checks++;
            if (q_src[i] !== 32'hA500_0004 + 32'(i)) begin
                errors++; $display("FAIL rd_basic_data%0d: got %h want %h", i, q_src[i], 32'hA500_0004 + 32'(i));
            end
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL rd_basic_done_cnt: got %0d want 1", done_cnt); end
        if (q_src.size() > 0) begin
            checks++;
            if (done_cyc !== q_src_cyc[q_src.size()-1] + 1) begin
                errors++; $display("FAIL rd_basic_done_cyc: got %0d want %0d", done_cyc, q_src_cyc[q_src.size()-1] + 1);
            end
        end
    endtask

    task automatic test_read_backpressure;
        int early;
        lat = 1; stall_mode = 0; rnd_mode = 0; src_mode = 1;
        run_op(1'b0, 15'h0200, 13'd20, 400);
        early = 0;
        foreach (q_iss_cyc[i]) if (q_iss_cyc[i] < 30) early++;
        checks++;
        if (timeout) begin errors++; $display("FAIL bp_timeout: got no done want done"); end
        checks++;
        if (early !== 8) begin errors++; $display("FAIL bp_credit: got %0d reads want 8", early); end
        checks++;
        if (rd_trace[29] !== 1'b0) begin errors++; $display("FAIL bp_read_drop: got avm_read=%b want 0", rd_trace[29]); end
        checks++;
        if (q_iss.size() !== 20) begin errors++; $display("FAIL bp_issue_cnt: got %0d want 20", q_iss.size()); end
        if (q_iss.size() > 8) begin
            checks++;
            if (q_iss_cyc[8] !== 31) begin errors++; $display("FAIL bp_resume: got cycle %0d want 31", q_iss_cyc[8]); end
        end
        checks++;
        if (q_src.size() !== 20) begin errors++; $display("FAIL bp_beats: got %0d want 20", q_src.size()); end
        for (int i = 0; i < 20 && i < q_src.size(); i++) begin
            checks++;
            if (q_src[i] !== ref_mem[13'h80 + 13'(i)]) begin
                errors++; $display("FAIL bp_data%0d: got %h want %h", i, q_src[i], ref_mem[13'h80 + 13'(i)]);
            end
        end
    endtask

    task automatic test_write_wait;
        logic [31:0] exp_d [3] = '{32'h11, 32'h22, 32'h33};
        lat = 1; stall_mode = 1; rnd_mode = 0; src_mode = 0; snk_mode = 0;
        q_snk = '{32'h11, 32'h22, 32'h33};
        run_op(1'b1, 15'h0100, 13'd3, 100);
        stall_mode = 0;
        checks++;
        if (timeout) begin errors++; $display("FAIL wr_timeout: got no done want done"); end
        checks++;
        if (hold_viol !== 0) begin errors++; $display("FAIL wr_hold: got %0d violations want 0", hold_viol); end
        checks++;
        if (rd_seen !== 0) begin errors++; $display("FAIL wr_no_read: got %0d read cycles want 0", rd_seen); end
        checks++;
        if (q_wa.size() !== 3) begin errors++; $display("FAIL wr_cnt: got %0d want 3", q_wa.size()); end
        for (int i = 0; i < 3; i++) begin
            ref_mem[13'h40 + 13'(i)] = exp_d[i];
            checks++;
            if (slave_word(13'h40 + 13'(i)) !== exp_d[i]) begin
                errors++; $display("FAIL wr_mem%0d: got %h want %h", i, slave_word(13'h40 + 13'(i)), exp_d[i]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL wr_done_cnt: got %0d want 1", done_cnt); end
        if (q_wc.size() == 3) begin
            checks++;
            if (done_cyc !== q_wc[2] + 1) begin errors++; $display("FAIL wr_done_cyc: got %0d want %0d", done_cyc, q_wc[2] + 1); end
        end
    endtask

    task automatic test_zero_len;
        lat = 1; stall_mode = 0; rnd_mode = 0; src_mode = 0;
        for (int w = 0; w < 2; w++) begin
            run_op(w[0], 15'h0300, 13'd0, 40);
            checks++;
            if (rd_seen + wr_seen !== 0) begin errors++; $display("FAIL zero_bus%0d: got %0d bus cycles want 0", w, rd_seen + wr_seen); end
            checks++;
            if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt%0d: got %0d want 1", w, done_cnt); end
            checks++;
            if (done_cyc !== acc_cyc + 1 || acc_cyc !== 0) begin
                errors++; $display("FAIL zero_done_cyc%0d: got accept %0d done %0d want 0 and 1", w, acc_cyc, done_cyc);
            end
        end
    endtask

    task automatic test_wrap;
        lat = 2; stall_mode = 0; rnd_mode = 0; src_mode = 0;
        run_op(1'b0, 15'h7FFC, 13'd2, 60);
        checks++;
        if (q_iss.size() !== 2) begin errors++; $display("FAIL wrap_cnt: got %0d want 2", q_iss.size()); end
        else begin
            checks++;
            if (q_iss[0] !== 15'h7FFC || q_iss[1] !== 15'h0000) begin
                errors++; $display("FAIL wrap_addr: got %h %h want 7ffc 0000", q_iss[0], q_iss[1]);
            end
        end
        checks++;
        if (q_src.size() !== 2 || q_src[0] !== ref_mem[8191] || q_src[1] !== ref_mem[0]) begin
            errors++; $display("FAIL wrap_data: got %0d beats want %h %h", q_src.size(), ref_mem[8191], ref_mem[0]);
        end
    endtask

    task automatic test_reset_mid;
        int iss, bad;
        lat = 6; stall_mode = 0; rnd_mode = 0; src_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 15'h0040; cmd_len = 13'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        iss = 0;
        for (int n = 0; n < 20 && iss < 3; n++) begin
            if (avm_read && !avm_waitrequest) iss++;
            @(negedge clk);
        end
        checks++;
        if (iss !== 3) begin errors++; $display("FAIL rst_mid_issue: got %0d reads want 3", iss); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, avm_read, avm_write, src_valid, snk_ready} !== 7'b1000000 ||
            avm_address !== 15'h0 || avm_writedata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got ctrl=%b addr=%h wdata=%h want 1000000 0 0",
                     {cmd_ready, busy, done, avm_read, avm_write, src_valid, snk_ready}, avm_address, avm_writedata);
        end
        reset_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (src_valid || busy || avm_read) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rst_mid_late_rdv: got %0d active cycles want 0", bad); end
        lat = 1; src_mode = 0;
        run_op(1'b0, 15'h0080, 13'd1, 40);
        checks++;
        if (q_src.size() !== 1 || q_src[0] !== ref_mem[13'h20]) begin
            errors++; $display("FAIL rst_mid_next_read: got %0d beats first %h want 1 beat %h", q_src.size(), q_src[0], ref_mem[13'h20]);
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL rst_mid_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random;
        logic        wr;
        logic [14:0] addr, wa;
        logic [12:0] len;
        logic [31:0] exp_d[$];
        for (int n = 0; n < 10; n++) begin
            wr = 1'($urandom_range(0, 1));
            addr = 15'($urandom);
            len = 13'($urandom_range(1, 24));
            lat = $urandom_range(1, 4);
            stall_mode = 0; rnd_mode = 1; src_mode = 2; snk_mode = 1;
            exp_d.delete();
            if (wr) for (int i = 0; i < int'(len); i++) exp_d.push_back($urandom);
            q_snk = exp_d;
            run_op(wr, addr, len, 2000);
            checks++;
            if (timeout || done_cnt !== 1) begin errors++; $display("FAIL rnd%0d_done: got timeout=%0d done=%0d want 0 1", n, timeout, done_cnt); end
            checks++;
            if (hold_viol !== 0) begin errors++; $display("FAIL rnd%0d_hold: got %0d want 0", n, hold_viol); end
            if (wr) begin
                checks++;
                if (q_wa.size() !== int'(len)) begin errors++; $display("FAIL rnd%0d_wcnt: got %0d want %0d", n, q_wa.size(), len); end
                for (int i = 0; i < int'(len) && i < q_wa.size(); i++) begin
                    wa = word_addr(addr, i);
                    ref_mem[wa[14:2]] = exp_d[i];
                    checks++;
                    if (q_wa[i] !== wa || q_wd[i] !== exp_d[i] || slave_word(wa[14:2]) !== exp_d[i]) begin
                        errors++; $display("FAIL rnd%0d_w%0d: got %h/%h want %h/%h", n, i, q_wa[i], q_wd[i], wa, exp_d[i]);
                    end
                end
            end else begin
                checks++;
                if (q_src.size() !== int'(len)) begin errors++; $display("FAIL rnd%0d_rcnt: got %0d want %0d", n, q_src.size(), len); end
                for (int i = 0; i < int'(len) && i < q_src.size(); i++) begin
                    wa = word_addr(addr, i);
                    checks++;
                    if (q_iss[i] !== wa || q_src[i] !== ref_mem[wa[14:2]]) begin
                        errors++; $display("FAIL rnd%0d_r%0d: got %h/%h want %h/%h", n, i, q_iss[i], q_src[i], wa, ref_mem[wa[14:2]]);
                    end
                end
            end
        end
        rnd_mode = 0;
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = 32'hA500_0000 + 32'(i);
        test_reset();
        test_read_basic();
        test_read_backpressure();
        test_write_wait();
        test_zero_len();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
